// File: rtl/game_flow_controller.sv
// Game sequencer: owns phase, player health and level, and gates the
// object layers (enable, level load, player visibility) accordingly.
module game_flow_controller #(
    parameter int START_HEALTH  = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8,
    parameter int BANNER_FRAMES = 90,
    parameter int MAX_LEVEL     = 9
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic [2:0] playerHitByRocket,
    input  logic       playerHitByAlien,
    input  logic       aliensReachedBorder,
    input  logic       allAliensDead,
    input  logic       GodMode,
    output logic [2:0] gameState,
    output logic [1:0] playerHealth,
    output logic [3:0] level,
    output logic       gameplayEnable,
    output logic       levelLoad,
    output logic       playerVisible,
    output logic       lost
);

    localparam int MAXF = (INVULN_FRAMES > BANNER_FRAMES) ?
                          INVULN_FRAMES : BANNER_FRAMES;
    localparam int CW = $clog2(MAXF + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_INV   = 3'd2,
        S_CLR   = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_health, w_health;
    logic [3:0]    r_level, w_level;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [BW-1:0] r_blink, w_blink;
    logic          r_vis, w_vis;
    logic          r_en, w_en;
    logic          r_start_d, r_rocket_d;
    logic          w_load;
    logic          w_start_edge, w_rocket_edge, w_expired, w_loss;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_health   <= 2'(START_HEALTH);
            r_level    <= 4'd1;
            r_cnt      <= '0;
            r_blink    <= '0;
            r_vis      <= 1'b1;
            r_en       <= 1'b0;
            r_start_d  <= 1'b0;
            r_rocket_d <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_health   <= w_health;
            r_level    <= w_level;
            r_cnt      <= w_cnt;
            r_blink    <= w_blink;
            r_vis      <= w_vis;
            r_en       <= w_en;
            r_start_d  <= startKey;
            r_rocket_d <= |playerHitByRocket;
        end
    end

    always_comb begin
        w_start_edge  = startKey & ~r_start_d;
        w_rocket_edge = (|playerHitByRocket) & ~r_rocket_d;
        w_expired     = (r_cnt == '0) & startOfFrame;
        w_loss        = aliensReachedBorder | playerHitByAlien;
        w_state       = r_state;
        w_health      = r_health;
        w_level       = r_level;
        w_cnt         = (startOfFrame && r_cnt != '0) ?
                        r_cnt - CW'(1) : r_cnt;
        w_blink       = r_blink;
        w_vis         = 1'b1;
        w_load        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state  = S_PLAY;
                    w_health = 2'(START_HEALTH);
                    w_level  = 4'd1;
                    w_load   = 1'b1;
                end
            end
            S_PLAY, S_INV: begin
                if (w_loss) begin
                    w_state  = S_OVER;
                    w_health = 2'd0;
                end else if (r_state == S_PLAY && w_rocket_edge && !GodMode) begin
                    if (r_health <= 2'd1) begin
                        w_health = 2'd0;
                        w_state  = S_OVER;
                    end else begin
                        w_health = r_health - 2'd1;
                        w_state  = S_INV;
                        w_cnt    = CW'(INVULN_FRAMES - 1);
                        w_blink  = '0;
                    end
                end else if (allAliensDead) begin
                    if (r_level == 4'(MAX_LEVEL)) begin
                        w_state = S_WIN;
                    end else begin
                        w_state = S_CLR;
                        w_cnt   = CW'(BANNER_FRAMES - 1);
                    end
                end else if (r_state == S_INV) begin
                    if (w_expired) begin
                        w_state = S_PLAY;
                    end else begin
                        // Toggle every BLINK_FRAMES frames, starting visible
                        w_vis = r_vis;
                        if (startOfFrame) begin
                            if (r_blink == BW'(BLINK_FRAMES - 1)) begin
                                w_blink = '0;
                                w_vis   = ~r_vis;
                            end else begin
                                w_blink = r_blink + BW'(1);
                            end
                        end
                    end
                end
            end
            S_CLR: begin
                if (w_expired) begin
                    w_state = S_PLAY;
                    w_level = r_level + 4'd1;
                    w_load  = 1'b1;
                end
            end
            S_OVER, S_WIN: begin
                if (w_start_edge) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        w_en = (w_state == S_PLAY) || (w_state == S_INV);
    end

    assign gameState      = r_state;
    assign playerHealth   = r_health;
    assign level          = r_level;
    assign gameplayEnable = r_en;
    assign playerVisible  = r_vis;
    assign levelLoad      = w_load & resetN;
    assign lost           = (r_state == S_OVER);

endmodule
